// File: rtl/axis_ptp_classifier.sv
// -----------------------------------------------------------------------------
// axis_ptp_classifier
//
// Passive monitor on an AXI4-Stream Ethernet frame stream. It watches the
// transferred beats (tvalid & tready), tracks the absolute byte offset inside
// the frame and decides once per frame whether it is a PTP (EtherType 0x88F7)
// frame, optionally sent to PTP_MAC. The result is announced with a one-cycle
// cls_valid strobe on the cycle after the deciding beat; the result fields are
// then held until the first beat of the next frame.
//
// Optional feature: define PTP_VLAN_EN to accept one 802.1Q tag (TPID 0x8100),
// which shifts the EtherType/messageType offsets by 4 and sets ptp_vlan.
// Without it, tagged frames are non-PTP and ptp_vlan is tied low.
//
// Ports:
//   axis_aclk, axis_aresetn  clock, asynchronous active-low reset
//   axis_tvalid/tready       monitored handshake (inputs only, never driven)
//   axis_tdata/tkeep/tlast   monitored beat; tkeep is honoured on tlast only
//   cls_valid                one strobe per frame carrying the result
//   is_ptp, ptp_msg_type     PTP flag and messageType (low nibble of byte 14/18)
//   ptp_event                messageType < 8
//   ptp_vlan                 frame carried one 802.1Q tag
// -----------------------------------------------------------------------------
module axis_ptp_classifier #(
    parameter int          DATA_WIDTH = 8,
    parameter int          MATCH_MAC  = 1,
    parameter logic [47:0] PTP_MAC    = 48'h0180C200000E
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic                    axis_tvalid,
    input  logic                    axis_tready,
    input  logic [DATA_WIDTH-1:0]   axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] axis_tkeep,
    input  logic                    axis_tlast,
    output logic                    cls_valid,
    output logic                    is_ptp,
    output logic [3:0]              ptp_msg_type,
    output logic                    ptp_event,
    output logic                    ptp_vlan
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, HDR, WAIT_LAST, DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] off_q, off_d;
    logic        et_hi_q, et_hi_d;      // EtherType high byte (0x88) seen
    logic        et_ok_q, et_ok_d;      // full EtherType 0x88F7 seen
    logic        cls_valid_q, is_ptp_q, ptp_event_q;
    logic [3:0]  msg_q;
    logic        beat, in_hdr, dec, ptp;
    logic [3:0]  msg;
    logic [12:0] pos, sum;
    logic [7:0]  b;
    logic [47:0] mac_sh;
`ifdef PTP_VLAN_EN
    logic        tpid_hi_q, tpid_hi_d;  // TPID high byte (0x81) seen
    logic        vlan_q, vlan_d;        // TPID 0x8100 seen, offsets shifted by 4
    logic        ptp_vlan_q;
`endif

    // Per-beat header evaluation: bytes are walked in ascending offset so a
    // mismatch or the messageType byte decides the frame at its exact position,
    // and later bytes of the same beat are ignored.
    always_comb begin
        beat    = axis_tvalid & axis_tready;
        in_hdr  = (state_q == IDLE) || (state_q == HDR);
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        et_hi_d = (state_q == IDLE) ? 1'b0 : et_hi_q;
        et_ok_d = (state_q == IDLE) ? 1'b0 : et_ok_q;
`ifdef PTP_VLAN_EN
        tpid_hi_d = (state_q == IDLE) ? 1'b0 : tpid_hi_q;
        vlan_d    = (state_q == IDLE) ? 1'b0 : vlan_q;
`endif
        dec    = 1'b0;
        ptp    = 1'b0;
        msg    = 4'h0;
        pos    = '0;
        b      = '0;
        mac_sh = '0;
        if (beat && in_hdr) begin
            for (int i = 0; i < NB; i++) begin
                pos    = 13'(off_q) + 13'(i);
                b      = axis_tdata[8*i +: 8];
                mac_sh = PTP_MAC << (8 * pos[2:0]);
                if (!dec && (!axis_tlast || axis_tkeep[i])) begin
                    if (MATCH_MAC != 0 && pos < 13'd6) begin
                        if (b != mac_sh[47:40]) dec = 1'b1;
                    end else if (pos == 13'd12) begin
                        et_hi_d = (b == 8'h88);
`ifdef PTP_VLAN_EN
                        tpid_hi_d = (b == 8'h81);
                        if (!et_hi_d && !tpid_hi_d) dec = 1'b1;
`else
                        if (!et_hi_d) dec = 1'b1;
`endif
                    end else if (pos == 13'd13) begin
`ifdef PTP_VLAN_EN
                        if (tpid_hi_d && b == 8'h00) vlan_d = 1'b1;
                        else if (et_hi_d && b == 8'hF7) et_ok_d = 1'b1;
                        else dec = 1'b1;
                    end else if (vlan_d && pos == 13'd16) begin
                        et_hi_d = (b == 8'h88);
                        if (!et_hi_d) dec = 1'b1;
                    end else if (vlan_d && pos == 13'd17) begin
                        if (et_hi_d && b == 8'hF7) et_ok_d = 1'b1;
                        else dec = 1'b1;
                    end else if (pos == (vlan_d ? 13'd18 : 13'd14)) begin
`else
                        if (et_hi_d && b == 8'hF7) et_ok_d = 1'b1;
                        else dec = 1'b1;
                    end else if (pos == 13'd14) begin
`endif
                        // et_ok_d guards against EtherType bytes dropped by tkeep.
                        dec = 1'b1;
                        ptp = et_ok_d;
                        msg = et_ok_d ? b[3:0] : 4'h0;
                    end
                end
            end
            if (axis_tlast) dec = 1'b1;
        end
    end

    // Offset advances per beat, saturates at 4095 and restarts after tlast.
    always_comb begin
        sum   = 13'(off_q) + 13'(NB);
        off_d = off_q;
        if (beat) off_d = axis_tlast ? 12'd0 : (sum[12] ? 12'hFFF : sum[11:0]);
    end

    // DONE is the cycle the strobe is out; the frame then waits for tlast.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HDR: if (beat) state_d = dec ? (axis_tlast ? IDLE : DONE) : HDR;
            DONE:      state_d = (beat && axis_tlast) ? IDLE : WAIT_LAST;
            WAIT_LAST: if (beat && axis_tlast) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q     <= IDLE;
            off_q       <= '0;
            et_hi_q     <= 1'b0;
            et_ok_q     <= 1'b0;
            cls_valid_q <= 1'b0;
            is_ptp_q    <= 1'b0;
            msg_q       <= 4'h0;
            ptp_event_q <= 1'b0;
`ifdef PTP_VLAN_EN
            tpid_hi_q   <= 1'b0;
            vlan_q      <= 1'b0;
            ptp_vlan_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            off_q       <= off_d;
            et_hi_q     <= et_hi_d;
            et_ok_q     <= et_ok_d;
            cls_valid_q <= dec;
`ifdef PTP_VLAN_EN
            tpid_hi_q   <= tpid_hi_d;
            vlan_q      <= vlan_d;
`endif
            // First beat of a frame clears the held result; a decision on the
            // same beat overrides the clear below.
            if (beat && state_q == IDLE) begin
                is_ptp_q    <= 1'b0;
                msg_q       <= 4'h0;
                ptp_event_q <= 1'b0;
`ifdef PTP_VLAN_EN
                ptp_vlan_q  <= 1'b0;
`endif
            end
            if (dec) begin
                is_ptp_q    <= ptp;
                msg_q       <= msg;
                ptp_event_q <= ptp & ~msg[3];
`ifdef PTP_VLAN_EN
                ptp_vlan_q  <= vlan_d;
`endif
            end
        end
    end

    assign cls_valid    = cls_valid_q;
    assign is_ptp       = is_ptp_q;
    assign ptp_msg_type = msg_q;
    assign ptp_event    = ptp_event_q;
`ifdef PTP_VLAN_EN
    assign ptp_vlan     = ptp_vlan_q;
`else
    assign ptp_vlan     = 1'b0;
`endif

endmodule

// File: doc/axis_ptp_classifier.md
AXIS_PTP_CLASSIFIER -- requirements
Module: axis_ptp_classifier

Interface
REQ-001 Parameter DATA_WIDTH, default 8: AXIS data width in bits; SHALL be one of 8, 16, 32 or 64.
REQ-002 Parameter MATCH_MAC, default 1: 1 requires the destination MAC to match; 0 classifies on EtherType only.
REQ-003 Parameter PTP_MAC, default 48'h0180C200000E: destination MAC to match, first wire byte in bits [47:40].
REQ-004 Port axis_aclk, input, 1: the single clock.
REQ-005 Port axis_aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 Port axis_tvalid, input, 1: monitored stream valid.
REQ-007 Port axis_tready, input, 1: monitored stream ready. A beat transfers when tvalid and tready are both 1.
REQ-008 Port axis_tdata, input, DATA_WIDTH: frame bytes; byte n of a beat is on bits [8n+7:8n].
REQ-009 Port axis_tkeep, input, DATA_WIDTH/8: byte enables; SHALL be honoured on the last beat only.
REQ-010 Port axis_tlast, input, 1: last beat of the frame.
REQ-011 Port cls_valid, output, 1: one-cycle strobe marking the classification result for the current frame.
REQ-012 Port is_ptp, output, 1: frame is PTP; held from the strobe until the next frame starts.
REQ-013 Port ptp_msg_type, output, 4: PTP messageType (low nibble of the first PTP header byte).
REQ-014 Port ptp_event, output, 1: set when ptp_msg_type < 8 (event message).
REQ-015 Port ptp_vlan, output, 1: frame carried one 802.1Q tag.

Function
REQ-016 The block SHALL be a passive monitor: it drives no handshake and never stalls the stream.
REQ-017 It SHALL keep a 12-bit byte offset. The offset advances by DATA_WIDTH/8 per transferred beat, saturates at 4095, and returns to 0 after the tlast beat.
REQ-018 Each valid byte SHALL be compared at its absolute offset: MAC at 0-5, EtherType at 12-13, messageType at 14. With a VLAN tag: TPID at 12-13, EtherType at 16-17, messageType at 18.
REQ-019 The FSM states SHALL be IDLE, HDR, WAIT_LAST and DONE.
- IDLE -> HDR on the first transferred beat.
- HDR -> WAIT_LAST once the result is issued.
- WAIT_LAST -> IDLE on the tlast beat.
REQ-020 A PTP frame requires all of the following:
- MAC matches PTP_MAC (ignored when MATCH_MAC=0);
- EtherType equals 0x88F7;
- the messageType byte has been received.
REQ-021 cls_valid SHALL pulse exactly once per frame, on the cycle after the beat that decides the result. Deciding beats are: the messageType beat; the first mismatching MAC or EtherType byte; or tlast.
REQ-022 A frame ending (tlast) before the messageType byte SHALL yield cls_valid with is_ptp=0, ptp_msg_type=0 and ptp_event=0.
REQ-023 When tlast coincides with the deciding beat, only one cls_valid SHALL be issued, and the FSM SHALL go to IDLE.
REQ-024 Bytes with tkeep=0 on the tlast beat SHALL be ignored for matching.
REQ-025 is_ptp, ptp_msg_type, ptp_event and ptp_vlan SHALL clear to 0 on the first beat of the next frame.
REQ-026 Beats with tvalid=0 or tready=0 SHALL change no state.

Reset
REQ-027 When axis_aresetn=0, all of the following SHALL clear immediately, independent of the clock:
- FSM to IDLE;
- offset to 0;
- cls_valid, is_ptp, ptp_msg_type, ptp_event and ptp_vlan to 0.
REQ-028 After a reset asserted mid-frame, the next transferred beat SHALL be treated as byte 0 of a new frame.

Configuration
REQ-029 With PTP_VLAN_EN defined, TPID 0x8100 at offset 12-13 SHALL shift the EtherType and messageType offsets by 4 and set ptp_vlan.
REQ-030 Without PTP_VLAN_EN, tagged frames SHALL classify as non-PTP, ptp_vlan SHALL be tied to 0, and no VLAN logic SHALL be synthesised.

Verification
REQ-031 DATA_WIDTH=8, untagged PTP Sync (MAC 01:80:C2:00:00:0E, 0x88F7, byte14=0x00) -> cls_valid the cycle after byte 14; is_ptp=1, ptp_msg_type=0, ptp_event=1.
REQ-032 DATA_WIDTH=64, Follow_Up (byte14=0x08) -> cls_valid after beat 1; is_ptp=1, ptp_msg_type=8, ptp_event=0.
REQ-033 MATCH_MAC=1, IPv4 frame to ff:ff:ff:ff:ff:ff -> cls_valid after byte 0; is_ptp=0; no second strobe at tlast.
REQ-034 PTP_VLAN_EN defined, tagged Delay_Req (0x8100, VID 5, 0x88F7, byte18=0x01) -> is_ptp=1, ptp_vlan=1, ptp_msg_type=1. Without the macro -> is_ptp=0.
REQ-035 10-byte runt ending with tlast, plus tvalid gaps and tready stalls mid-header -> single cls_valid after tlast with is_ptp=0; stalls add no strobes.
REQ-036 axis_aresetn pulsed low at byte 7 of a PTP frame, then a new PTP frame -> outputs clear immediately; the new frame classifies is_ptp=1.
